bus_scheduler: RTL and testbench
================================

// Module: bus_scheduler
// PURPOSE
//  Split-aware bus ownership scheduler for the 2-initiator serial bus. Replaces fixed-priority
//  arbitration: round-robin between initiators, priority for split-target responses, parks an
//  initiator whose transaction was split, optional hung-owner watchdog. Sits beside the bus
//  fabric; its grant/sel outputs drive the forward mux and grant routing.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles an owner may hold the bus before forced release (watchdog only)
//  CNT_W           $clog2(TIMEOUT_CYCLES+1)  watchdog counter width
// PORTS
//  clk          in   1  bus clock; single clock domain
//  rst          in   1  asynchronous, active-high reset
//  req_i_1      in   1  initiator-1 port arbiter request, level, held for whole transaction
//  req_i_2      in   1  initiator-2 port arbiter request
//  req_split    in   1  split target requests bus to return deferred data
//  split_ack    in   1  split target accepted addr and deferred; valid only in GNT_I1/GNT_I2
//  split_done   in   1  split target final ack of deferred response; valid only in GNT_SPLIT
//  grant_i_1    out  1  bus owned by initiator 1 (registered)
//  grant_i_2    out  1  bus owned by initiator 2 (registered)
//  grant_split  out  1  bus owned by split target (registered)
//  sel          out  2  init_sel_t: INIT_1/INIT_2 while initiator owns; INIT_NONE otherwise
//  split_owner  out  2  init_sel_t of parked initiator awaiting split data; INIT_NONE if none
//  timeout      out  1  one-cycle pulse on forced release (0 when watchdog compiled out)
// BEHAVIOUR
//  - FSM states: IDLE, GNT_I1, GNT_I2, GNT_SPLIT. All outputs registered, one-hot grants.
//  - Reset: state=IDLE, all grants 0, sel=INIT_NONE, split_owner=INIT_NONE, rr_last=INIT_2
//    (initiator 1 wins first tie), timeout=0, counter=0. Reset mid-transaction aborts at once.
//  - Eligible: elig_1 = req_i_1 & (split_owner!=INIT_1); elig_2 likewise.
//  - IDLE: req_split -> GNT_SPLIT (highest priority); else one eligible -> its GNT; both eligible
//    -> the one != rr_last. Grant rises the cycle after req seen (1-cycle latency).
//  - GNT_Ix: hold while req_i_x=1. req_i_x=0 -> IDLE, rr_last<=x. split_ack=1 -> IDLE,
//    split_owner<=x, rr_last<=x (takes precedence over req drop in same cycle).
//  - GNT_SPLIT: hold while req_split=1; split_done=1 -> split_owner<=INIT_NONE; req_split=0 ->
//    IDLE. split_done and req drop same cycle: both take effect. rr_last unchanged.
//  - Every release passes through IDLE: >=1 dead cycle with no grant between owners.
//  - split_ack outside GNT_Ix and split_done outside GNT_SPLIT are ignored.
//  - Second split_ack while split_owner!=INIT_NONE: overwrite owner (flag as assertion error).
// CONFIGURATION
//  BUS_SCHED_WATCHDOG_EN defined: counter clears on entry to any GNT state, increments each
//  owned cycle; when it reaches TIMEOUT_CYCLES-1 the owner is released to IDLE next cycle,
//  timeout pulses 1 cycle, rr_last<=owner; GNT_SPLIT timeout also clears split_owner.
//  Not defined: no counter, timeout tied 0, ownership unbounded.
// STRUCTURE
//  bus_pkg: init_sel_t {INIT_NONE=2'b00, INIT_1=2'b01, INIT_2=2'b10}, sched_state_t.
//  Sub-module bus_sched_watchdog (counter+compare), instantiated only under the macro.
// TESTING
//  1. req_i_1=req_i_2=1 out of reset -> grant_i_1 @+1; drop req_i_1 -> idle cycle, grant_i_2.
//  2. Both reqs held, each released after 4 cycles, 6 rounds -> strict alternation 1,2,1,2,...
//  3. GNT_I1, split_ack=1 -> split_owner=INIT_1, grant_i_1=0; req_i_1 still 1 -> never granted;
//     req_i_2 granted next; later req_split -> grant_split, split_done -> split_owner=INIT_NONE.
//  4. req_split and req_i_1 rise same cycle in IDLE -> grant_split first, grant_i_1 after.
//  5. Watchdog, TIMEOUT_CYCLES=8, req_i_2 stuck 1 -> grant_i_2 8 cycles, timeout pulse, release.
//  6. rst=1 during GNT_SPLIT with split_owner=INIT_2 -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types for the 2-initiator bus ownership scheduler.
//   init_sel_t    : initiator select code, used for sel, split_owner and rr_last
//   sched_state_t : ownership FSM state
package bus_pkg;

    typedef enum logic [1:0] {
        INIT_NONE = 2'b00,
        INIT_1    = 2'b01,
        INIT_2    = 2'b10
    } init_sel_t;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        GNT_I1    = 2'b01,
        GNT_I2    = 2'b10,
        GNT_SPLIT = 2'b11
    } sched_state_t;

endpackage

// File: rtl/bus_sched_watchdog.sv
// Hung-owner watchdog: counts owned cycles and flags expiry once the current
// owner has held the bus for TIMEOUT_CYCLES cycles.
//   clk, rst   : bus clock, async active-high reset
//   start_i    : bus is being granted this cycle (clears the count)
//   owned_i    : some agent owns the bus this cycle
//   expire_o   : current owner has used its last allowed cycle
module bus_sched_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic start_i,
    input  logic owned_i,
    output logic expire_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Count is 0 in the first owned cycle, so expiry lands on the last one.
    assign expire_o = owned_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (start_i) begin
            cnt_d = '0;
        end else if (owned_i && !expire_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bus_scheduler.sv
// Split-aware bus ownership scheduler for the 2-initiator serial bus.
// Round-robin between initiators, priority for split-target responses, parks an
// initiator whose transaction was split. Optional hung-owner watchdog when
// BUS_SCHED_WATCHDOG_EN is defined.
// Ports:
//   clk, rst             : bus clock, async active-high reset
//   req_i_1, req_i_2     : initiator requests, held for the whole transaction
//   req_split            : split target wants the bus to return deferred data
//   split_ack            : target deferred the current initiator's transaction
//   split_done           : target's final ack of the deferred response
//   grant_i_1/_i_2/split : registered one-hot ownership
//   sel                  : owning initiator, INIT_NONE otherwise
//   split_owner          : parked initiator awaiting split data
//   timeout              : one-cycle pulse on watchdog forced release
//
// state     | meaning
// IDLE      | nobody owns the bus; arbitration happens here
// GNT_I1    | initiator 1 owns the bus
// GNT_I2    | initiator 2 owns the bus
// GNT_SPLIT | split target owns the bus to return deferred data
module bus_scheduler
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      req_i_1,
    input  logic      req_i_2,
    input  logic      req_split,
    input  logic      split_ack,
    input  logic      split_done,
    output logic      grant_i_1,
    output logic      grant_i_2,
    output logic      grant_split,
    output init_sel_t sel,
    output init_sel_t split_owner,
    output logic      timeout
);

    sched_state_t state_q, state_d;
    init_sel_t    rr_last_q, rr_last_d;
    init_sel_t    split_owner_q, split_owner_d;
    init_sel_t    sel_q;
    logic         grant_i_1_q, grant_i_2_q, grant_split_q;
    logic         timeout_q, timeout_d;
    logic         elig_1, elig_2;
    logic         owner_req;
    init_sel_t    owner;
    logic         ack_taken;
    logic         wd_expire;

`ifdef BUS_SCHED_WATCHDOG_EN
    bus_sched_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .start_i  ((state_q == IDLE) && (state_d != IDLE)),
        .owned_i  (state_q != IDLE),
        .expire_o (wd_expire)
    );
`else
    assign wd_expire = 1'b0;

    // Keeps the watchdog parameters referenced when the counter is compiled out.
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif

    assign elig_1 = req_i_1 && (split_owner_q != INIT_1);
    assign elig_2 = req_i_2 && (split_owner_q != INIT_2);

    always_comb begin
        state_d       = state_q;
        rr_last_d     = rr_last_q;
        split_owner_d = split_owner_q;
        timeout_d     = 1'b0;
        ack_taken     = 1'b0;
        owner         = (state_q == GNT_I1) ? INIT_1 : INIT_2;
        owner_req     = (state_q == GNT_I1) ? req_i_1 : req_i_2;

        case (state_q)
            IDLE: begin
                if (req_split) begin
                    state_d = GNT_SPLIT;
                end else if (elig_1 && elig_2) begin
                    state_d = (rr_last_q == INIT_1) ? GNT_I2 : GNT_I1;
                end else if (elig_1) begin
                    state_d = GNT_I1;
                end else if (elig_2) begin
                    state_d = GNT_I2;
                end
            end
            GNT_I1, GNT_I2: begin
                // A split parks the initiator even if it drops its request together.
                if (split_ack) begin
                    state_d       = IDLE;
                    split_owner_d = owner;
                    rr_last_d     = owner;
                    ack_taken     = 1'b1;
                end else if (!owner_req) begin
                    state_d   = IDLE;
                    rr_last_d = owner;
                end else if (wd_expire) begin
                    state_d   = IDLE;
                    rr_last_d = owner;
                    timeout_d = 1'b1;
                end
            end
            GNT_SPLIT: begin
                if (split_done) begin
                    split_owner_d = INIT_NONE;
                end
                if (!req_split) begin
                    state_d = IDLE;
                end else if (wd_expire) begin
                    state_d       = IDLE;
                    split_owner_d = INIT_NONE;
                    timeout_d     = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_last_q     <= INIT_2;
            split_owner_q <= INIT_NONE;
            sel_q         <= INIT_NONE;
            grant_i_1_q   <= 1'b0;
            grant_i_2_q   <= 1'b0;
            grant_split_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            rr_last_q     <= rr_last_d;
            split_owner_q <= split_owner_d;
            grant_i_1_q   <= (state_d == GNT_I1);
            grant_i_2_q   <= (state_d == GNT_I2);
            grant_split_q <= (state_d == GNT_SPLIT);
            sel_q         <= (state_d == GNT_I1) ? INIT_1 :
                             (state_d == GNT_I2) ? INIT_2 : INIT_NONE;
            timeout_q     <= timeout_d;
        end
    end

    // A new split while another initiator is still parked loses the old owner.
    split_overwrite_a: assert property (@(posedge clk) disable iff (rst)
        ack_taken |-> (split_owner_q == INIT_NONE));

    assign grant_i_1   = grant_i_1_q;
    assign grant_i_2   = grant_i_2_q;
    assign grant_split = grant_split_q;
    assign sel         = sel_q;
    assign split_owner = split_owner_q;
    assign timeout     = timeout_q;

endmodule

// File: tb/tb_bus_scheduler.sv
module tb_bus_scheduler;

    localparam int TB_T = 8;
`ifdef BUS_SCHED_WATCHDOG_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       req_i_1, req_i_2, req_split, split_ack, split_done;
    logic       grant_i_1, grant_i_2, grant_split, timeout;
    logic [1:0] sel, split_owner;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bus_scheduler #(.TIMEOUT_CYCLES(TB_T)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i_1     (req_i_1),
        .req_i_2     (req_i_2),
        .req_split   (req_split),
        .split_ack   (split_ack),
        .split_done  (split_done),
        .grant_i_1   (grant_i_1),
        .grant_i_2   (grant_i_2),
        .grant_split (grant_split),
        .sel         (sel),
        .split_owner (split_owner),
        .timeout     (timeout)
    );

    // Owner: 0 none, 1/2 initiator, 3 split target. held = cycles the grant has been visible.
    typedef struct {
        int owner;
        int park;
        int rr;
        int held;
        bit to;
    } model_t;

    model_t m;

    function automatic model_t model_reset();
        model_t r;
        r.owner = 0; r.park = 0; r.rr = 2; r.held = 0; r.to = 1'b0;
        return r;
    endfunction

    function automatic model_t model_step(model_t c, bit r1, bit r2, bit rs, bit sa, bit sd);
        model_t n = c;
        bit want;
        bit e1, e2;
        n.to = 1'b0;
        if (c.owner == 0) begin
            e1 = r1 && (c.park != 1);
            e2 = r2 && (c.park != 2);
            if (rs)             n.owner = 3;
            else if (e1 && e2)  n.owner = (c.rr == 1) ? 2 : 1;
            else if (e1)        n.owner = 1;
            else if (e2)        n.owner = 2;
            n.held = (n.owner != 0) ? 1 : 0;
        end else if (c.owner == 3) begin
            if (sd) n.park = 0;
            if (!rs) n.owner = 0;
            else if (WD && c.held == TB_T) begin
                n.owner = 0; n.park = 0; n.to = 1'b1;
            end else n.held = c.held + 1;
        end else begin
            want = (c.owner == 1) ? r1 : r2;
            if (sa) begin
                n.park = c.owner; n.rr = c.owner; n.owner = 0;
            end else if (!want) begin
                n.rr = c.owner; n.owner = 0;
            end else if (WD && c.held == TB_T) begin
                n.rr = c.owner; n.owner = 0; n.to = 1'b1;
            end else n.held = c.held + 1;
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, req_i_1, req_i_2, req_split, split_ack, split_done);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        check("m_grant_i_1",   32'(grant_i_1),   32'(m.owner == 1));
        check("m_grant_i_2",   32'(grant_i_2),   32'(m.owner == 2));
        check("m_grant_split", 32'(grant_split), 32'(m.owner == 3));
        check("m_sel",         32'(sel),         (m.owner == 1 || m.owner == 2) ? m.owner : 0);
        check("m_split_owner", 32'(split_owner), m.park);
        check("m_timeout",     32'(timeout),     32'(m.to));
    end

    task automatic wait_grant(output int who);
        who = 0;
        for (int i = 0; i < 12 && who == 0; i++) begin
            @(negedge clk);
            if (grant_i_1)        who = 1;
            else if (grant_i_2)   who = 2;
            else if (grant_split) who = 3;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench time limit");
    end

    initial begin
        int w;
        int n;
        rst = 1'b1;
        req_i_1 = 0; req_i_2 = 0; req_split = 0; split_ack = 0; split_done = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_grants", {grant_i_1, grant_i_2, grant_split}, 0);
        check("rst_sel", sel, 0);
        check("rst_split_owner", split_owner, 0);
        check("rst_timeout", timeout, 0);

        // 1: both request out of reset, initiator 1 first, dead cycle, then 2
        req_i_1 = 1; req_i_2 = 1;
        @(negedge clk);
        check("t1_grant_i_1", grant_i_1, 1);
        check("t1_sel", sel, 1);
        @(negedge clk);
        req_i_1 = 0;
        @(negedge clk);
        check("t1_dead_cycle", {grant_i_1, grant_i_2, grant_split}, 0);
        @(negedge clk);
        check("t1_grant_i_2", grant_i_2, 1);
        check("t1_sel2", sel, 2);
        req_i_2 = 0;
        repeat (2) @(negedge clk);

        // 2: both held, each owner releases after 4 cycles, 12 grants alternate
        req_i_1 = 1; req_i_2 = 1;
        for (int k = 0; k < 12; k++) begin
            wait_grant(w);
            check("t2_order", w, ((k % 2) == 0) ? 1 : 2);
            repeat (3) @(negedge clk);
            if (w == 1) req_i_1 = 0; else req_i_2 = 0;
            @(negedge clk);
            if (w == 1) req_i_1 = 1; else req_i_2 = 1;
        end
        req_i_1 = 0; req_i_2 = 0;
        repeat (3) @(negedge clk);

        // 3: split parks initiator 1 until the split target completes
        req_i_1 = 1;
        wait_grant(w);
        check("t3_first", w, 1);
        split_ack = 1;
        @(negedge clk);
        split_ack = 0;
        check("t3_released", grant_i_1, 0);
        check("t3_parked", split_owner, 1);
        req_i_2 = 1;
        wait_grant(w);
        check("t3_other", w, 2);
        repeat (2) @(negedge clk);
        req_i_2 = 0;
        repeat (4) @(negedge clk);
        check("t3_still_parked", grant_i_1, 0);
        req_split = 1;
        wait_grant(w);
        check("t3_split_grant", w, 3);
        split_done = 1;
        @(negedge clk);
        split_done = 0;
        check("t3_unparked", split_owner, 0);
        req_split = 0;
        wait_grant(w);
        check("t3_regrant", w, 1);
        req_i_1 = 0;
        repeat (2) @(negedge clk);

        // 4: split request beats a same-cycle initiator request
        req_split = 1; req_i_1 = 1;
        wait_grant(w);
        check("t4_split_first", w, 3);
        repeat (2) @(negedge clk);
        req_split = 0;
        wait_grant(w);
        check("t4_then_i1", w, 1);
        req_i_1 = 0;
        repeat (2) @(negedge clk);

`ifdef BUS_SCHED_WATCHDOG_EN
        // 5: stuck request is released after TB_T owned cycles
        req_i_2 = 1;
        wait_grant(w);
        check("t5_grant", w, 2);
        n = 0;
        while (grant_i_2 && n < 20) begin
            n++;
            @(negedge clk);
        end
        req_i_2 = 0;
        check("t5_held_cycles", n, 8);
        check("t5_timeout_pulse", timeout, 1);
        @(negedge clk);
        check("t5_timeout_once", timeout, 0);
        repeat (2) @(negedge clk);
`endif

        // 6: async reset while split target owns and initiator 2 is parked
        req_i_2 = 1;
        wait_grant(w);
        check("t6_grant", w, 2);
        split_ack = 1;
        @(negedge clk);
        split_ack = 0;
        check("t6_parked", split_owner, 2);
        req_split = 1;
        wait_grant(w);
        check("t6_split", w, 3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_grants", {grant_i_1, grant_i_2, grant_split}, 0);
        check("t6_rst_sel", sel, 0);
        check("t6_rst_split_owner", split_owner, 0);
        check("t6_rst_timeout", timeout, 0);
        @(negedge clk);
        req_i_2 = 0; req_split = 0;
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
